// File: rtl/logic_gate_pkg.sv
// Shared types and the bitwise reduction used by the logic pipe.
// Latency: none (types and a combinational helper function only).
// Backpressure: not applicable.
package logic_gate_pkg;

    localparam int OP_W      = 3;
    localparam int CNT_W_DEF = 16;

    // Upper bounds for the shared reduction helper; WIDTH must not exceed MAX_W.
    localparam int MAX_W  = 64;
    localparam int MAX_IN = 8;

    typedef enum logic [OP_W-1:0] {
        OP_AND     = 3'd0,
        OP_OR      = 3'd1,
        OP_XOR     = 3'd2,
        OP_NAND    = 3'd3,
        OP_NOR     = 3'd4,
        OP_XNOR    = 3'd5,
        OP_PASS    = 3'd6,
        OP_ILLEGAL = 3'd7
    } op_e;

    typedef logic [MAX_IN-1:0][MAX_W-1:0] opnd_vec_t;

    // Bitwise reduction of the first n operands; XOR is per-bit odd parity.
    function automatic logic [MAX_W-1:0] logic_reduce(input op_e op,
                                                      input opnd_vec_t opnds,
                                                      input int unsigned n);
        logic [MAX_W-1:0] r_and;
        logic [MAX_W-1:0] r_or;
        logic [MAX_W-1:0] r_xor;
        logic [MAX_W-1:0] r;
        r_and = '1;
        r_or  = '0;
        r_xor = '0;
        for (int unsigned i = 0; i < MAX_IN; i++) begin
            if (i < n) begin
                r_and = r_and & opnds[i];
                r_or  = r_or  | opnds[i];
                r_xor = r_xor ^ opnds[i];
            end
        end
        case (op)
            OP_AND:     r = r_and;
            OP_OR:      r = r_or;
            OP_XOR:     r = r_xor;
            OP_NAND:    r = ~r_and;
            OP_NOR:     r = ~r_or;
            OP_XNOR:    r = ~r_xor;
            OP_PASS:    r = opnds[0];
            OP_ILLEGAL: r = '0;
            default:    r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_gate_pipe_if.sv
// Streaming bus of the logic pipe: operand input, result output, status.
// Latency: none (wiring only).
// Backpressure: in_ready/out_ready valid-ready handshakes on each side.
interface logic_gate_pipe_if
    import logic_gate_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2,
    parameter int CNT_W  = CNT_W_DEF
);
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [OP_W-1:0]         in_op;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_y;
    logic [OP_W-1:0]         out_op;
    logic [CNT_W-1:0]        out_count;
    logic                    err_op;

    // Producer/consumer side (bench or upstream proxy).
    modport master (
        output in_valid, in_data, in_op, out_ready,
        input  in_ready, out_valid, out_y, out_op, out_count, err_op
    );

    // The logic pipe itself.
    modport slave (
        input  in_valid, in_data, in_op, out_ready,
        output in_ready, out_valid, out_y, out_op, out_count, err_op
    );
endinterface

// File: rtl/logic_pipe_stage.sv
// One elastic register stage: holds a valid bit and a data word.
// Latency: 1 cycle from upstream acceptance to downstream valid.
// Backpressure: ready upstream when empty or draining this cycle (comb from dn_rdy_i).
module logic_pipe_stage #(
    parameter int DW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_vld_i,
    input  logic [DW-1:0] up_dat_i,
    output logic          up_rdy_o,
    output logic          dn_vld_o,
    output logic [DW-1:0] dn_dat_o,
    input  logic          dn_rdy_i
);
    logic          vld_q;
    logic          vld_d;
    logic [DW-1:0] dat_q;
    logic [DW-1:0] dat_d;
    logic          load;

    assign up_rdy_o = ~vld_q | dn_rdy_i;
    assign load     = up_vld_i & up_rdy_o;
    assign dn_vld_o = vld_q;
    assign dn_dat_o = dat_q;

    // Next state: load on acceptance, empty when drained with nothing behind.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (load) begin
            vld_d = 1'b1;
            dat_d = up_dat_i;
        end else if (dn_rdy_i) begin
            vld_d = 1'b0;
        end
    end

    // Stage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end
endmodule

// File: rtl/logic_gate_pipe.sv
// Pipelined multi-operand bitwise logic unit with op select, counter and error flag.
// Latency: STAGES cycles from acceptance to out_valid with no stall.
// Backpressure: elastic chain; in_ready is comb from out_ready, capacity STAGES.
module logic_gate_pipe
    import logic_gate_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2,
    parameter int STAGES = 2,
    parameter int CNT_W  = CNT_W_DEF
) (
    input logic               clk,
    input logic               rst,
    logic_gate_pipe_if.slave  bus
);
    localparam int DW = WIDTH + OP_W;

    opnd_vec_t        opnds;
    logic [WIDTH-1:0] y_comb;

    logic [STAGES:0]  vld;
    logic [STAGES:0]  rdy;
    logic [DW-1:0]    dat [STAGES+1];

    logic             accept;
    logic             consume;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             err_q;
    logic             err_d;

    // Spread the packed operand bus into the reduction helper's fixed-size slots.
    always_comb begin
        opnds = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            opnds[i][WIDTH-1:0] = bus.in_data[i*WIDTH +: WIDTH];
        end
    end

    assign y_comb = WIDTH'(logic_reduce(op_e'(bus.in_op), opnds, NUM_IN));

    assign vld[0]      = bus.in_valid;
    assign dat[0]      = {y_comb, bus.in_op};
    assign rdy[STAGES] = bus.out_ready;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic_pipe_stage #(.DW(DW)) u_stage (
            .clk      (clk),
            .rst      (rst),
            .up_vld_i (vld[g]),
            .up_dat_i (dat[g]),
            .up_rdy_o (rdy[g]),
            .dn_vld_o (vld[g+1]),
            .dn_dat_o (dat[g+1]),
            .dn_rdy_i (rdy[g+1])
        );
    end

    // Reset masks ready so nothing is accepted while the chain is being cleared.
    assign bus.in_ready  = rdy[0] & ~rst;
    assign bus.out_valid = vld[STAGES];
    assign bus.out_y     = dat[STAGES][DW-1:OP_W];
    assign bus.out_op    = dat[STAGES][OP_W-1:0];
    assign bus.out_count = cnt_q;
    assign bus.err_op    = err_q;

    assign accept  = bus.in_valid & bus.in_ready;
    assign consume = vld[STAGES] & bus.out_ready;

    // Counter advances per consumption (wraps naturally); err flag is sticky.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (consume) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (accept && (bus.in_op == OP_ILLEGAL)) begin
            err_d = 1'b1;
        end
    end

    // Status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
endmodule

// File: doc/logic_gate_pipe.md
# logic_gate_pipe

Parametrised, pipelined multi-operand bitwise logic unit. It replaces the single fixed 1-bit AND gate under co-simulation with a streaming unit that covers:
- configurable operand width, operand count and pipeline depth;
- a per-transaction operation select;
- valid/ready flow control with backpressure;
- a completed-transaction counter and a sticky illegal-op flag.

It sits behind the HDL-side proxy and is driven by the same testbench flow.

## Interface
- WIDTH, 8, bits per operand and result (>=1)
- NUM_IN, 2, number of operands (2..8)
- STAGES, 2, pipeline register stages, input to output (1..8)
- CNT_W, 16, width of the transaction counter
- clk  input  1  single clock, rising edge
- rst  input  1  reset: synchronous and active-high
- in_valid  input  1  operand set presented
- in_ready  output  1  unit can accept this cycle
- in_data  input  NUM_IN*WIDTH  operands, operand i at bits [i*WIDTH +: WIDTH]
- in_op  input  3  operation code
- out_valid  output  1  result presented
- out_ready  input  1  consumer accepts this cycle
- out_y  output  WIDTH  result
- out_op  output  3  op code that produced out_y
- out_count  output  CNT_W  results consumed since reset
- err_op  output  1  sticky illegal-op flag

## Operation
- Op codes: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 PASS (operand 0), 7 ILLEGAL.
- Every op is bitwise across all NUM_IN operands; XOR is odd parity per bit.
- The result is computed combinationally from in_data/in_op and captured into stage 0 on acceptance. Later stages carry {y, op} unchanged.
- ILLEGAL: result is all zeros and err_op sets on acceptance. err_op stays high until rst; no other clear.
- Elastic pipeline: each stage holds a valid bit. Stage i loads from stage i-1 when stage i is empty or is itself advancing this cycle.
- The last stage drives out_valid/out_y/out_op. It advances when out_ready=1.
- in_ready = stage 0 empty, or stage 0 advancing this cycle. The full pipeline runs bubble-free, one transaction per cycle.
- Acceptance: in_valid & in_ready at the edge. Consumption: out_valid & out_ready at the edge.
- out_count increments by 1 per consumption and wraps from 2^CNT_W-1 to 0.
- Handshake rules:
  - out_y and out_op hold stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a consumption.
  - Order is strictly preserved.
  - in_data and in_op are sampled only at acceptance.
  - Simultaneous accept and consume on a full pipeline is legal and loses nothing.

## Timing
- Latency: a transaction accepted at edge k shows out_valid=1 in the cycle after edge k+STAGES-1, i.e. STAGES cycles with no stall.
- Throughput: 1 per cycle while out_ready=1. Capacity is exactly STAGES transactions.
- Reset (rst=1 at an edge): all stage valids, out_y, out_op, out_count and err_op clear to 0.
- in_ready is 0 while rst=1 and returns to 1 the first cycle after rst is released.
- Reset mid-operation discards all in-flight transactions. No result appears after release unless new input is accepted.
- in_ready may depend combinationally on out_ready. No other input-to-output combinational path exists.

## Structure
- Package logic_gate_pkg holds:
  - op_e enum (the 8 codes above) and the 3-bit op width constant;
  - default CNT_W;
  - function logic_reduce(op, operands) shared by RTL and bench model.
- Sub-module logic_pipe_stage: one elastic register stage (valid, data, upstream ready). It is instantiated STAGES times via generate, with data width WIDTH+3.
- Top level contains the operand reduction, stage chain, counter and err_op register.

## Test plan
Bench configuration is WIDTH=8, NUM_IN=3, STAGES=2.
- Reset, then operands {0xFF,0x0F,0x3C}, op AND, out_ready=1 -> out_y=0x0C, out_op=0, out_valid two cycles after acceptance, out_count=1.
- Same operands, ops OR/XOR/NAND/NOR/XNOR/PASS back-to-back -> 0xFF, 0xCC, 0xF3, 0x00, 0x33, 0x3C in order on consecutive cycles, no bubbles.
- Hold out_ready=0, stream 3 inputs -> in_ready drops after 2 accepted. out_y is stable on the first result. Raising out_ready drains all 3 in order, out_count=3.
- Op 7 with any operands -> out_y=0x00, err_op=1 and staying high through later legal ops until rst.
- Fill pipeline, assert rst for one cycle mid-stream -> out_valid=0 and out_count=0 next cycle, no stale results after release.
- Run 2^CNT_W+2 consumptions (CNT_W overridden to 4) -> out_count wraps 15->0 and reads 2 at the end.
